// File: rtl/pc_stack_if.sv
// Control-unit <-> PC/stack unit bus: sequencing strobes in, PC and stack status out.
// master = control unit, slave = pc_stack_unit.
interface pc_stack_if #(
    parameter int PC_WIDTH    = 10,
    parameter int STACK_DEPTH = 8
);
    localparam int LW = $clog2(STACK_DEPTH + 1);

    logic                we_reg;
    logic                we_pc;
    logic [1:0]          s_pc;
    logic [PC_WIDTH-1:0] jmp_target;
    logic                push;
    logic                pop;
    logic                err_clr;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] ret_addr;
    logic [LW-1:0]       level;
    logic                full;
    logic                empty;
    logic                ovf;
    logic                unf;

    modport master (
        output we_reg, we_pc, s_pc, jmp_target, push, pop, err_clr,
        input  pc, ret_addr, level, full, empty, ovf, unf
    );

    modport slave (
        input  we_reg, we_pc, s_pc, jmp_target, push, pop, err_clr,
        output pc, ret_addr, level, full, empty, ovf, unf
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC latches, trap vector and a checked return-address stack.
// Stack top is read asynchronously so a return (s_pc=2 with pop) completes in one cycle.
module pc_stack_unit #(
    parameter int PC_WIDTH    = 10,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0,
    parameter int VECTOR      = 1008
) (
    input  logic       clk,
    input  logic       reset,
    pc_stack_if.slave  bus
);
    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] inc_latch_q, inc_latch_d;
    logic [PC_WIDTH-1:0] jmp_latch_q, jmp_latch_d;
    logic [LW-1:0]       level_q, level_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [PC_WIDTH-1:0] mem_wdata;

    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] top;
    logic [LW-1:0]       level_m1;
    logic                full;
    logic                empty;

    assign pc_plus1 = pc_q + PC_WIDTH'(1);
    assign level_m1 = level_q - LW'(1);
    assign full     = (level_q == LW'(STACK_DEPTH));
    assign empty    = (level_q == '0);
    assign top      = empty ? '0 : stack_mem[level_m1[AW-1:0]];

    always_comb begin
        pc_d        = pc_q;
        inc_latch_d = inc_latch_q;
        jmp_latch_d = jmp_latch_q;
        if (bus.we_reg) begin
            inc_latch_d = pc_plus1;
            jmp_latch_d = bus.jmp_target;
        end
        if (bus.we_pc) begin
            case (bus.s_pc)
                2'd0:    pc_d = inc_latch_q;
                2'd1:    pc_d = jmp_latch_q;
                2'd2:    pc_d = top;
                default: pc_d = PC_WIDTH'(VECTOR);
            endcase
        end
    end

    always_comb begin
        level_d   = level_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_waddr = level_q[AW-1:0];
        // A trap saves the interrupted PC itself so it can be re-executed on return.
        mem_wdata = (bus.we_pc && bus.s_pc == 2'd3) ? pc_q : pc_plus1;
        if (bus.err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        case ({bus.push, bus.pop})
            2'b10: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    level_d = level_q + LW'(1);
                end
            end
            2'b01: begin
                if (empty) unf_d = 1'b1;
                else       level_d = level_m1;
            end
            2'b11: begin
                mem_we = 1'b1;
                if (empty) begin
                    unf_d   = 1'b1;
                    level_d = LW'(1);
                end else begin
                    mem_waddr = level_m1[AW-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= PC_WIDTH'(RESET_PC);
            inc_latch_q <= '0;
            jmp_latch_q <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            inc_latch_q <= inc_latch_d;
            jmp_latch_q <= jmp_latch_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Stack contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) stack_mem[mem_waddr] <= mem_wdata;
    end

    assign bus.pc       = pc_q;
    assign bus.ret_addr = top;
    assign bus.level    = level_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit (PC_WIDTH=10, STACK_DEPTH=4, VECTOR=0x3F0).
module tb_pc_stack_unit;
    typedef struct packed {
        logic [9:0] pc;
        logic [9:0] ret;
        logic [2:0] level;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } st_t;

    typedef struct {
        string name;
        st_t   st;
    } rec_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    rec_t exp_q[$];
    st_t  got_q[$];

    pc_stack_if #(.PC_WIDTH(10), .STACK_DEPTH(4)) ifc ();

    pc_stack_unit #(
        .PC_WIDTH(10), .STACK_DEPTH(4), .RESET_PC(0), .VECTOR(12'h3F0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic st_t mk(input int pc, input int ret, input int lvl, input int ovf, input int unf);
        st_t s;
        s.pc    = 10'(pc);
        s.ret   = 10'(ret);
        s.level = 3'(lvl);
        s.full  = (lvl == 4);
        s.empty = (lvl == 0);
        s.ovf   = (ovf != 0);
        s.unf   = (unf != 0);
        return s;
    endfunction

    function automatic st_t snap();
        st_t s;
        s.pc    = ifc.pc;
        s.ret   = ifc.ret_addr;
        s.level = ifc.level;
        s.full  = ifc.full;
        s.empty = ifc.empty;
        s.ovf   = ifc.ovf;
        s.unf   = ifc.unf;
        return s;
    endfunction

    task automatic clear_inputs();
        ifc.we_reg  = 1'b0;
        ifc.we_pc   = 1'b0;
        ifc.s_pc    = 2'd0;
        ifc.push    = 1'b0;
        ifc.pop     = 1'b0;
        ifc.err_clr = 1'b0;
    endtask

    // One clock with the currently driven inputs; optionally queue expected/observed state.
    task automatic cyc(input bit chk, input string name, input st_t e);
        rec_t r;
        @(posedge clk);
        #1;
        if (chk) begin
            r.name = name;
            r.st   = e;
            exp_q.push_back(r);
            got_q.push_back(snap());
        end
        clear_inputs();
    endtask

    task automatic set_pc(input int v);
        ifc.jmp_target = 10'(v);
        ifc.we_reg     = 1'b1;
        cyc(0, "", '0);
        ifc.we_pc = 1'b1;
        ifc.s_pc  = 2'd1;
        cyc(0, "", '0);
    endtask

    task automatic test_reset();
        rec_t r;
        st_t  g;
        reset = 1'b1;
        ifc.push = 1'b1; ifc.we_pc = 1'b1; ifc.s_pc = 2'd3;
        cyc(1, "reset0", mk(0, 0, 0, 0, 0));
        cyc(1, "reset1", mk(0, 0, 0, 0, 0));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifc.we_reg = 1'b1;
            cyc(1, $sformatf("inc_latch%0d", i), mk(i, 0, 0, 0, 0));
            ifc.we_pc = 1'b1; ifc.s_pc = 2'd0;
            cyc(1, $sformatf("inc_pc%0d", i), mk(i + 1, 0, 0, 0, 0));
        end
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== r.st) begin bad++; $display("FAIL %s got=%h exp=%h", r.name, g, r.st); end
            else $display("txn %s ok state=%h", r.name, g);
        end
    endtask

    task automatic test_call_return();
        rec_t r;
        st_t  g;
        set_pc(5);
        ifc.jmp_target = 10'h100; ifc.we_reg = 1'b1;
        cyc(1, "call_latch", mk(5, 0, 0, 0, 0));
        ifc.we_pc = 1'b1; ifc.s_pc = 2'd1; ifc.push = 1'b1;
        cyc(1, "call", mk(12'h100, 6, 1, 0, 0));
        ifc.we_pc = 1'b1; ifc.s_pc = 2'd2; ifc.pop = 1'b1;
        cyc(1, "return", mk(6, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== r.st) begin bad++; $display("FAIL %s got=%h exp=%h", r.name, g, r.st); end
            else $display("txn %s ok state=%h", r.name, g);
        end
    endtask

    task automatic test_overflow_underflow();
        rec_t r;
        st_t  g;
        for (int i = 0; i < 5; i++) begin
            set_pc(12'h010 + i);
            ifc.push = 1'b1;
            cyc(1, $sformatf("push%0d", i),
                mk(12'h010 + i, 12'h011 + ((i < 4) ? i : 3), (i < 4) ? i + 1 : 4, (i == 4), 0));
        end
        for (int i = 0; i < 5; i++) begin
            int lvl;
            lvl = (i < 4) ? 3 - i : 0;
            ifc.pop = 1'b1;
            cyc(1, $sformatf("pop%0d", i), mk(12'h014, (lvl == 0) ? 0 : 12'h010 + lvl, lvl, 1, (i == 4)));
        end
        ifc.err_clr = 1'b1;
        cyc(1, "err_clr", mk(12'h014, 0, 0, 0, 0));
        ifc.err_clr = 1'b1; ifc.pop = 1'b1;
        cyc(1, "clr_vs_unf", mk(12'h014, 0, 0, 0, 1));
        ifc.err_clr = 1'b1;
        cyc(1, "err_clr2", mk(12'h014, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== r.st) begin bad++; $display("FAIL %s got=%h exp=%h", r.name, g, r.st); end
            else $display("txn %s ok state=%h", r.name, g);
        end
    endtask

    task automatic test_wrap();
        rec_t r;
        st_t  g;
        set_pc(12'h3FF);
        ifc.we_reg = 1'b1; ifc.push = 1'b1;
        cyc(1, "wrap_push", mk(12'h3FF, 0, 1, 0, 0));
        ifc.we_pc = 1'b1; ifc.s_pc = 2'd0;
        cyc(1, "wrap_pc", mk(0, 0, 1, 0, 0));
        ifc.pop = 1'b1;
        cyc(1, "wrap_pop", mk(0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== r.st) begin bad++; $display("FAIL %s got=%h exp=%h", r.name, g, r.st); end
            else $display("txn %s ok state=%h", r.name, g);
        end
    endtask

    task automatic test_trap_and_pushpop();
        rec_t r;
        st_t  g;
        set_pc(12'h020);
        ifc.we_pc = 1'b1; ifc.s_pc = 2'd3; ifc.push = 1'b1;
        cyc(1, "trap", mk(12'h3F0, 12'h020, 1, 0, 0));
        for (int k = 2; k <= 4; k++) begin
            ifc.push = 1'b1;
            cyc(1, $sformatf("fill%0d", k), mk(12'h3F0, 12'h3F1, k, 0, 0));
        end
        set_pc(12'h030);
        ifc.push = 1'b1; ifc.pop = 1'b1;
        cyc(1, "pushpop_full", mk(12'h030, 12'h031, 4, 0, 0));
        ifc.we_pc = 1'b1; ifc.s_pc = 2'd2; ifc.pop = 1'b1;
        cyc(1, "ret_b2b", mk(12'h031, 12'h3F1, 3, 0, 0));
        ifc.push = 1'b1;
        cyc(1, "push_refill", mk(12'h031, 12'h032, 4, 0, 0));
        ifc.push = 1'b1;
        cyc(1, "push_ovf", mk(12'h031, 12'h032, 4, 1, 0));
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== r.st) begin bad++; $display("FAIL %s got=%h exp=%h", r.name, g, r.st); end
            else $display("txn %s ok state=%h", r.name, g);
        end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        st_t  g;
        ifc.pop = 1'b1;
        cyc(1, "drain3", mk(12'h031, 12'h3F1, 3, 1, 0));
        ifc.pop = 1'b1;
        cyc(1, "drain2", mk(12'h031, 12'h3F1, 2, 1, 0));
        reset = 1'b1;
        ifc.push = 1'b1; ifc.we_pc = 1'b1; ifc.s_pc = 2'd1;
        cyc(1, "reset_mid", mk(0, 0, 0, 0, 0));
        reset = 1'b0;
        ifc.push = 1'b1; ifc.pop = 1'b1;
        cyc(1, "pushpop_empty", mk(0, 1, 1, 0, 1));
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== r.st) begin bad++; $display("FAIL %s got=%h exp=%h", r.name, g, r.st); end
            else $display("txn %s ok state=%h", r.name, g);
        end
    endtask

    initial begin
        reset = 1'b1;
        ifc.jmp_target = '0;
        clear_inputs();
        #2;
        test_reset();
        test_call_return();
        test_overflow_underflow();
        test_wrap();
        test_trap_and_pushpop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
